// File: rtl/fire_dispatch_multi.sv
// Multi-channel fire dispatcher: queues global synapse index ranges and issues them one index per cycle.
// Optional FIRE_DISPATCH_STATS_EN adds a saturating 16-bit dispatch_count output.
module fire_dispatch_multi #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10,
  parameter int QDEPTH = 2,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int IDX_W = ADDR_W + CH_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [IDX_W-1:0]         syn_start,
  input  logic [IDX_W-1:0]         syn_end,
  input  logic                     syn_in_vld,
  output logic                     syn_in_rdy,
  output logic [NUM_CH-1:0]        syn_vld,
  output logic [NUM_CH*ADDR_W-1:0] syn_addr,
  input  logic [NUM_CH-1:0]        syn_rdy,
  output logic                     step_done,
  output logic                     range_err
`ifdef FIRE_DISPATCH_STATS_EN
  ,
  output logic [15:0]              dispatch_count
`endif
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  cur_idx_reg, cur_idx_next;
  logic [IDX_W-1:0]  last_idx_reg, last_idx_next;
  logic [IDX_W-1:0]  q_start_mem [QDEPTH];
  logic [IDX_W-1:0]  q_end_mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              range_err_reg;
  logic              q_empty, q_full;
  logic              accept, bad_range, push, pop, hs;
  logic [CH_W-1:0]   cur_ch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_empty    = (count_reg == '0);
  assign q_full     = (count_reg == CNT_W'(QDEPTH));
  assign syn_in_rdy = reset_n && enable && !q_full;
  assign accept     = syn_in_vld && syn_in_rdy;
  assign bad_range  = (syn_start > syn_end);
  assign push       = accept && !bad_range;
  assign cur_ch     = cur_idx_reg[IDX_W-1:ADDR_W];
  assign hs         = |(syn_vld & syn_rdy);
  assign range_err  = range_err_reg;
  assign step_done  = (state_reg == IDLE) && q_empty && !range_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign syn_vld[gi] = (state_reg == ISSUE) && (cur_ch == CH_W'(gi));
      assign syn_addr[gi*ADDR_W +: ADDR_W] = cur_idx_reg[ADDR_W-1:0];
    end
  endgenerate

  // Completing a range and popping the next one share an edge, so ranges chain with no bubble.
  always_comb begin
    state_next    = state_reg;
    cur_idx_next  = cur_idx_reg;
    last_idx_next = last_idx_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && !q_empty) begin
          pop           = 1'b1;
          state_next    = ISSUE;
          cur_idx_next  = q_start_mem[rd_ptr_reg];
          last_idx_next = q_end_mem[rd_ptr_reg];
        end
      end
      ISSUE: begin
        if (hs) begin
          if (cur_idx_reg != last_idx_reg) begin
            cur_idx_next = cur_idx_reg + 1'b1;
          end else if (enable && !q_empty) begin
            pop           = 1'b1;
            cur_idx_next  = q_start_mem[rd_ptr_reg];
            last_idx_next = q_end_mem[rd_ptr_reg];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cur_idx_reg   <= '0;
      last_idx_reg  <= '0;
      range_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_idx_reg   <= cur_idx_next;
      last_idx_reg  <= last_idx_next;
      range_err_reg <= accept && bad_range;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_start_mem[wr_ptr_reg] <= syn_start;
      q_end_mem[wr_ptr_reg]   <= syn_end;
    end
  end

`ifdef FIRE_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dispatch_count <= '0;
    end else if (hs && (dispatch_count != 16'hFFFF)) begin
      dispatch_count <= dispatch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fire_dispatch_multi.sv
// Bench for fire_dispatch_multi: directed scenarios plus randomized traffic against an index-stream model.
module tb_fire_dispatch_multi;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 10;
  localparam int QDEPTH = 2;
  localparam int IDX_W  = ADDR_W + $clog2(NUM_CH);

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     enable = 1'b0;
  logic [IDX_W-1:0]         syn_start = '0;
  logic [IDX_W-1:0]         syn_end = '0;
  logic                     syn_in_vld = 1'b0;
  logic                     syn_in_rdy;
  logic [NUM_CH-1:0]        syn_vld;
  logic [NUM_CH*ADDR_W-1:0] syn_addr;
  logic [NUM_CH-1:0]        syn_rdy = '0;
  logic                     step_done;
  logic                     range_err;
`ifdef FIRE_DISPATCH_STATS_EN
  logic [15:0]              dispatch_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  fire_dispatch_multi #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .syn_start(syn_start), .syn_end(syn_end), .syn_in_vld(syn_in_vld),
    .syn_in_rdy(syn_in_rdy), .syn_vld(syn_vld), .syn_addr(syn_addr),
    .syn_rdy(syn_rdy), .step_done(step_done), .range_err(range_err)
`ifdef FIRE_DISPATCH_STATS_EN
    , .dispatch_count(dispatch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH-1:0] exp_vld(input logic [IDX_W-1:0] idx);
    return NUM_CH'(1) << idx[IDX_W-1:ADDR_W];
  endfunction

  function automatic logic [NUM_CH*ADDR_W-1:0] exp_addr(input logic [IDX_W-1:0] idx);
    return {NUM_CH{idx[ADDR_W-1:0]}};
  endfunction

  task automatic offer(input int s, input int e);
    syn_start  = IDX_W'(s);
    syn_end    = IDX_W'(e);
    syn_in_vld = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; syn_in_vld = 1'b0; syn_rdy = '0;
    #2;
    n_vec++; if (syn_vld !== '0) begin n_err++; $display("FAIL reset_vld got=%h want=0", syn_vld); end
    n_vec++; if (syn_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%h want=0", syn_addr); end
    n_vec++; if (step_done !== 1'b1) begin n_err++; $display("FAIL reset_step_done got=%b want=1", step_done); end
    n_vec++; if (syn_in_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_rdy got=%b want=0", syn_in_rdy); end
    n_vec++; if (range_err !== 1'b0) begin n_err++; $display("FAIL reset_range_err got=%b want=0", range_err); end
`ifdef FIRE_DISPATCH_STATS_EN
    n_vec++; if (dispatch_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", dispatch_count); end
`endif
    tick(); tick();
    reset_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_channel_cross();
    logic [IDX_W-1:0] idx;
    enable = 1'b1; syn_rdy = '1;
    offer(12'h3FE, 12'h401);
    #1;
    n_vec++; if (syn_in_rdy !== 1'b1) begin n_err++; $display("FAIL cross_in_rdy got=%b want=1", syn_in_rdy); end
    tick();
    syn_in_vld = 1'b0;
    n_vec++; if (syn_vld !== '0) begin n_err++; $display("FAIL cross_latency got=%b want=0", syn_vld); end
    tick();
    for (int k = 0; k < 4; k++) begin
      idx = IDX_W'(12'h3FE + k);
      n_vec++;
      if (syn_vld !== exp_vld(idx) || syn_addr !== exp_addr(idx)) begin
        n_err++;
        $display("FAIL cross_issue k=%0d got vld=%b addr=%h want vld=%b addr=%h", k, syn_vld, syn_addr, exp_vld(idx), exp_addr(idx));
      end
      tick();
    end
    n_vec++; if (syn_vld !== '0 || step_done !== 1'b1) begin n_err++; $display("FAIL cross_end got vld=%b done=%b want 0/1", syn_vld, step_done); end
`ifdef FIRE_DISPATCH_STATS_EN
    n_vec++; if (dispatch_count !== 16'd4) begin n_err++; $display("FAIL cross_count got=%0d want=4", dispatch_count); end
`endif
    $display("test_channel_cross done");
  endtask

  task automatic test_back_to_back();
    int seq [3] = '{5, 6, 9};
    logic [IDX_W-1:0] idx;
    syn_rdy = '1;
    offer(5, 6);
    tick();
    offer(9, 9);
    #1;
    n_vec++; if (syn_in_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_in_rdy got=%b want=1", syn_in_rdy); end
    tick();
    syn_in_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = IDX_W'(seq[k]);
      n_vec++;
      if (syn_vld !== exp_vld(idx) || syn_addr !== exp_addr(idx)) begin
        n_err++;
        $display("FAIL b2b_issue k=%0d got vld=%b addr=%h want idx=%0d", k, syn_vld, syn_addr, idx);
      end
      tick();
    end
    n_vec++; if (syn_vld !== '0 || step_done !== 1'b1) begin n_err++; $display("FAIL b2b_end got vld=%b done=%b want 0/1", syn_vld, step_done); end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    syn_rdy = 4'b1110;
    offer(7, 7);
    tick();
    syn_in_vld = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (syn_vld !== 4'b0001 || syn_addr !== exp_addr(IDX_W'(7))) begin
        n_err++;
        $display("FAIL stall_hold k=%0d got vld=%b addr=%h want vld=0001 addr=7", k, syn_vld, syn_addr);
      end
      tick();
    end
    syn_rdy = '1;
    #1;
    n_vec++; if (syn_vld !== 4'b0001) begin n_err++; $display("FAIL stall_4th got vld=%b want=0001", syn_vld); end
    tick();
    n_vec++; if (syn_vld !== '0 || step_done !== 1'b1) begin n_err++; $display("FAIL stall_end got vld=%b done=%b want 0/1", syn_vld, step_done); end
    $display("test_stall done");
  endtask

  task automatic test_bad_range();
    syn_rdy = '1;
    offer(10, 4);
    #1;
    n_vec++; if (syn_in_rdy !== 1'b1) begin n_err++; $display("FAIL bad_in_rdy got=%b want=1", syn_in_rdy); end
    tick();
    syn_in_vld = 1'b0;
    n_vec++;
    if (range_err !== 1'b1 || syn_vld !== '0 || step_done !== 1'b0) begin
      n_err++;
      $display("FAIL bad_pulse got err=%b vld=%b done=%b want 1/0/0", range_err, syn_vld, step_done);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (range_err !== 1'b0 || syn_vld !== '0 || step_done !== 1'b1) begin
        n_err++;
        $display("FAIL bad_after k=%0d got err=%b vld=%b done=%b want 0/0/1", k, range_err, syn_vld, step_done);
      end
    end
    $display("test_bad_range done");
  endtask

  task automatic test_backpressure();
    int waited;
    syn_rdy = 4'b1011;
    offer(2048, 2049);
    tick();
    offer(2050, 2050);
    #1;
    n_vec++; if (syn_in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy2 got=%b want=1", syn_in_rdy); end
    tick();
    offer(2051, 2051);
    #1;
    n_vec++; if (syn_in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy3 got=%b want=1", syn_in_rdy); end
    tick();
    syn_in_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (syn_in_rdy !== 1'b0 || syn_vld !== 4'b0100) begin
        n_err++;
        $display("FAIL bp_full k=%0d got rdy=%b vld=%b want 0/0100", k, syn_in_rdy, syn_vld);
      end
      tick();
    end
    syn_rdy = '1;
    tick();
    n_vec++; if (syn_in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_midrange got rdy=%b want=0", syn_in_rdy); end
    tick();
    n_vec++;
    if (syn_in_rdy !== 1'b1 || syn_vld !== 4'b0100 || syn_addr !== exp_addr(IDX_W'(2050))) begin
      n_err++;
      $display("FAIL bp_release got rdy=%b vld=%b addr=%h want 1/0100/idx2050", syn_in_rdy, syn_vld, syn_addr);
    end
    waited = 0;
    while (step_done !== 1'b1 && waited < 20) begin tick(); waited++; end
    n_vec++; if (step_done !== 1'b1) begin n_err++; $display("FAIL bp_drain got done=%b want=1 after %0d cycles", step_done, waited); end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    syn_rdy = '1;
    offer(0, 100);
    tick();
    syn_in_vld = 1'b0;
    repeat (6) tick();
    n_vec++; if (syn_vld !== 4'b0001) begin n_err++; $display("FAIL mid_busy got vld=%b want=0001", syn_vld); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (syn_vld !== '0 || syn_addr !== '0 || step_done !== 1'b1 || syn_in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async got vld=%b addr=%h done=%b rdy=%b want 0/0/1/0", syn_vld, syn_addr, step_done, syn_in_rdy);
    end
`ifdef FIRE_DISPATCH_STATS_EN
    n_vec++; if (dispatch_count !== 16'd0) begin n_err++; $display("FAIL mid_count got=%0d want=0", dispatch_count); end
`endif
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (syn_vld !== '0 || step_done !== 1'b1) begin
        n_err++;
        $display("FAIL mid_after k=%0d got vld=%b done=%b want 0/1", k, syn_vld, step_done);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [IDX_W-1:0] exp_q [$];
    logic [IDX_W-1:0] idx;
    logic err_exp, err_next;
    int s, e, sel, n_acc;
    bit drain;
    err_exp = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drain = (cyc >= 500);
      if (drain) begin
        enable = 1'b1; syn_rdy = '1; syn_in_vld = 1'b0;
      end else begin
        enable = ($urandom_range(0, 9) != 0);
        for (int c = 0; c < NUM_CH; c++) syn_rdy[c] = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 3);
        if (sel == 0) begin
          s = $urandom_range(0, 2) * 1024 + 1024 - $urandom_range(1, 3);
          e = s + $urandom_range(0, 5);
        end else if (sel == 1) begin
          s = $urandom_range(10, 4000);
          e = s - $urandom_range(1, 5);
        end else begin
          s = $urandom_range(0, 4089);
          e = s + $urandom_range(0, 5);
        end
        syn_start  = IDX_W'(s);
        syn_end    = IDX_W'(e);
        syn_in_vld = ($urandom_range(0, 9) < 4);
      end
      #1;
      n_vec++;
      if (range_err !== err_exp) begin
        n_err++; $display("FAIL rnd_range_err cyc=%0d got=%b want=%b", cyc, range_err, err_exp);
      end
      n_vec++;
      if (step_done !== (exp_q.size() == 0 && !err_exp)) begin
        n_err++; $display("FAIL rnd_step_done cyc=%0d got=%b want=%b", cyc, step_done, (exp_q.size() == 0 && !err_exp));
      end
      if (!enable) begin
        n_vec++;
        if (syn_in_rdy !== 1'b0) begin n_err++; $display("FAIL rnd_rdy_disabled cyc=%0d got=%b want=0", cyc, syn_in_rdy); end
      end
      if (syn_vld !== '0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious cyc=%0d got vld=%b want none", cyc, syn_vld);
        end else begin
          idx = exp_q[0];
          if (syn_vld !== exp_vld(idx) || syn_addr !== exp_addr(idx)) begin
            n_err++;
            $display("FAIL rnd_issue cyc=%0d got vld=%b addr=%h want idx=%h", cyc, syn_vld, syn_addr, idx);
          end
        end
      end
      if (|(syn_vld & syn_rdy) && exp_q.size() != 0) void'(exp_q.pop_front());
      err_next = 1'b0;
      if (syn_in_vld && syn_in_rdy) begin
        n_acc++;
        if (syn_start <= syn_end) begin
          for (int i = int'(syn_start); i <= int'(syn_end); i++) exp_q.push_back(IDX_W'(i));
        end else begin
          err_next = 1'b1;
        end
      end
      tick();
      err_exp = err_next;
    end
    n_vec++;
    if (exp_q.size() != 0 || step_done !== 1'b1) begin
      n_err++; $display("FAIL rnd_drain got pending=%0d done=%b want 0/1", exp_q.size(), step_done);
    end
    $display("test_random done, %0d ranges accepted", n_acc);
  endtask

  initial begin
    test_reset();
    test_channel_cross();
    test_back_to_back();
    test_stall();
    test_bad_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fire_dispatch_multi.md
FIRE_DISPATCH_MULTI -- requirements
Module: fire_dispatch_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of synapse channels; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 10: per-channel synapse address width.
REQ-003 Parameter QDEPTH, default 2: depth of the pending-range queue, 1..8.
REQ-004 Derived IDX_W = ADDR_W + log2(NUM_CH): global synapse index width; index[IDX_W-1:ADDR_W] selects the channel.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  admits new ranges; gates queue pops.
REQ-008 syn_start  in  IDX_W  first global index of the range.
REQ-009 syn_end  in  IDX_W  last global index of the range, inclusive.
REQ-010 syn_in_vld  in  1  range offered.
REQ-011 syn_in_rdy  out  1  range can be accepted.
REQ-012 syn_vld  out  NUM_CH  per-channel address valid, at most one bit high.
REQ-013 syn_addr  out  NUM_CH*ADDR_W  per-channel address; slice c is bits [c*ADDR_W +: ADDR_W].
REQ-014 syn_rdy  in  NUM_CH  per-channel ready.
REQ-015 step_done  out  1  no queued or in-flight work.
REQ-016 range_err  out  1  one-cycle pulse: a range was rejected.

Function
REQ-017 Range acceptance SHALL occur on a rising edge with syn_in_vld && syn_in_rdy.
REQ-018 syn_in_rdy SHALL equal enable && queue not full; it is combinational and has no full-queue bypass.
REQ-019 An accepted range with syn_start > syn_end SHALL NOT be enqueued; range_err SHALL pulse high the following cycle.
REQ-020 Queue SHALL be FIFO; QDEPTH valid ranges accepted back-to-back SHALL all be held without loss.
REQ-021 Issue FSM states: IDLE and ISSUE.
- IDLE -> ISSUE on an edge with enable && queue non-empty: pop the head, cur_idx = start, last_idx = end.
REQ-022 In ISSUE, syn_vld[cur_idx[IDX_W-1:ADDR_W]] SHALL be 1, all other syn_vld bits 0, and every syn_addr slice SHALL equal cur_idx[ADDR_W-1:0].
REQ-023 An issue handshake is syn_vld[c] && syn_rdy[c] at an edge; without one, valid and address SHALL hold stable.
REQ-024 On a handshake with cur_idx != last_idx, cur_idx SHALL increment by 1; crossing a channel boundary incurs no bubble.
REQ-025 On a handshake with cur_idx == last_idx:
- if enable && queue non-empty, pop the next range in the same edge (zero bubble, stay in ISSUE);
- otherwise go to IDLE.
REQ-026 Throughput SHALL be one index per cycle while the addressed syn_rdy is high.
REQ-027 Latency from acceptance into an empty, idle block to first syn_vld SHALL be 2 cycles: accept edge, then pop edge.
REQ-028 enable low SHALL NOT abort an in-flight range; it blocks only acceptance and pops.
REQ-029 step_done SHALL equal (state == IDLE) && queue empty && !range_err, and SHALL be combinational.
REQ-030 Index arithmetic SHALL be unsigned IDX_W-bit; because start <= end is enforced, no wrap-around can occur.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, queue empty, cur_idx = 0, last_idx = 0, range_err = 0.
REQ-032 Outputs under reset: syn_vld all 0, syn_addr 0, step_done 1, syn_in_rdy 0 (because enable is low or the block is in reset).
REQ-033 Reset asserted mid-range SHALL discard all pending and in-flight work; no handshake completes after reset asserts.

Configuration
REQ-034 Macro FIRE_DISPATCH_STATS_EN:
- Defined: adds output dispatch_count, 16 bits; it increments on each issue handshake, saturates at 0xFFFF, and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-035 NUM_CH=4, ADDR_W=10; range 0x3FE..0x401, all syn_rdy high -> ch0 addr 0x3FE, 0x3FF, then ch1 addr 0x000, 0x001 on consecutive cycles; step_done returns high.
REQ-036 Ranges 5..6 and 9..9 accepted back-to-back, rdy high -> indices 5, 6, 9 issued on three consecutive cycles with no bubble.
REQ-037 Range 7..7 with syn_rdy[0] low for 3 cycles -> syn_vld[0]=1 and addr 7 held stable for 3 cycles; handshake completes on the 4th.
REQ-038 Range 10..4 offered -> accepted, range_err pulses once, no syn_vld, step_done stays high afterwards.
REQ-039 QDEPTH=2; three ranges offered while ch2 is stalled -> syn_in_rdy low after 2 accepts plus 1 in flight; it rises after the first range completes.
REQ-040 reset_n pulsed low mid-range 0..100 -> syn_vld drops asynchronously, queue empty, step_done=1; with the macro defined, dispatch_count=0.
